// File: rtl/uart_pixel_loader.sv
// UART 8N1 receiver that streams received bytes into an image memory, one write per byte,
// until a full image has been loaded.
module uart_pixel_loader #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned IMG_BYTES    = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        receive,
    input  logic        rx,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        load_done,
    output logic        frame_err,
    output logic        rx_LED
);

    localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0] ImgLast  = 17'(IMG_BYTES - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWrite} state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_sync_q;
    logic        receive_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic [16:0] count_q, count_d;
    logic        load_done_q, load_done_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_led_q, rx_led_d;
    logic [15:0] addr_q;
    logic [7:0]  din_q;
    logic        baud_hit;
    logic        start_ok;

    // START samples mid start bit; every other state waits a full bit period
    always_comb begin
        baud_hit = (state_q == StStart) ? (baud_q == HalfLast) : (baud_q == BitLast);
        start_ok = !rx_sync_q && receive && !load_done_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StStart;
            StStart: if (baud_hit) state_d = rx_sync_q ? StIdle : StData;
            StData:  if (baud_hit && bit_q == 3'd7) state_d = StStop;
            StStop:  if (baud_hit) state_d = rx_sync_q ? StWrite : StIdle;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_we = (state_q == StWrite);
    end

    always_comb begin
        load_done_d = load_done_q;
        frame_err_d = frame_err_q;
        count_d     = count_q;
        // Re-arming receive after a finished image starts a fresh one
        if (receive && !receive_q && load_done_q) begin
            load_done_d = 1'b0;
            frame_err_d = 1'b0;
            count_d     = '0;
        end
        if (state_q == StStop && baud_hit && !rx_sync_q) frame_err_d = 1'b1;
        if (state_q == StWrite) begin
            count_d = count_q + 17'd1;
            if (count_q == ImgLast) load_done_d = 1'b1;
        end
        rx_led_d = (state_d != StIdle) || (receive && !load_done_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            receive_q   <= 1'b0;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            count_q     <= '0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            rx_led_q    <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            receive_q   <= receive;
            count_q     <= count_d;
            load_done_q <= load_done_d;
            frame_err_q <= frame_err_d;
            rx_led_q    <= rx_led_d;
            case (state_q)
                StIdle: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                end
                StStart: baud_q <= baud_hit ? 16'd0 : baud_q + 16'd1;
                StData: begin
                    if (baud_hit) begin
                        baud_q  <= '0;
                        bit_q   <= bit_q + 3'd1;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StStop: begin
                    baud_q <= baud_q + 16'd1;
                    // Latch address/data on entry to WRITE so they hold afterwards
                    if (baud_hit && rx_sync_q) begin
                        addr_q <= count_q[15:0];
                        din_q  <= shift_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign load_done = load_done_q;
    assign frame_err = frame_err_q;
    assign rx_LED    = rx_led_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Scoreboard bench for uart_pixel_loader: expected writes are queued as frames are sent and
// matched against every observed mem_we pulse.
module tb_uart_pixel_loader;

    localparam int unsigned Cpb = 4;
    localparam int unsigned Img = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        receive = 1'b0;
    logic        rx = 1'b1;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        load_done;
    logic        frame_err;
    logic        rx_LED;

    int total = 0;
    int bad   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_w;

    uart_pixel_loader #(
        .CLKS_PER_BIT(Cpb),
        .IMG_BYTES   (Img)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .receive  (receive),
        .rx       (rx),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .load_done(load_done),
        .frame_err(frame_err),
        .rx_LED   (rx_LED)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Any write without a queued expectation is an error
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check_eq("unexp_we", 32'(mem_we), 32'd0);
            end else begin
                exp_w = exp_q.pop_front();
                check_eq("wr_addr", 32'(mem_addr), 32'(exp_w[23:8]));
                check_eq("wr_din", 32'(mem_din), 32'(exp_w[7:0]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        idle(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(Cpb);
        end
        rx = stop;
        idle(Cpb);
        rx = 1'b1;
        idle(2 * Cpb);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic check_outputs_reset(input string tag);
        check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_din"}, 32'(mem_din), 32'd0);
        check_eq({tag, "_done"}, 32'(load_done), 32'd0);
        check_eq({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check_eq({tag, "_led"}, 32'(rx_LED), 32'd0);
    endtask

    initial begin
        logic [7:0] img [4];
        img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56; img[3] = 8'h78;

        // Reset state
        idle(3);
        check_outputs_reset("rst");
        rst_n = 1'b1;
        idle(2);

        // Full image load
        receive = 1'b1;
        idle(2);
        check_eq("led_armed", 32'(rx_LED), 32'd1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({16'(i), img[i]});
            send_byte(img[i], 1'b1);
        end
        check_eq("img_done", 32'(load_done), 32'd1);
        check_eq("img_ferr", 32'(frame_err), 32'd0);
        check_eq("img_pending", 32'(exp_q.size()), 32'd0);
        check_eq("img_led", 32'(rx_LED), 32'd0);

        // Frame after load_done is ignored; re-arming starts a new image
        send_byte(8'hEE, 1'b1);
        check_eq("ign_addr", 32'(mem_addr), 32'd3);
        receive = 1'b0;
        idle(1);
        receive = 1'b1;
        idle(2);
        check_eq("rearm_done", 32'(load_done), 32'd0);
        exp_q.push_back({16'd0, 8'h99});
        send_byte(8'h99, 1'b1);
        check_eq("rearm_pending", 32'(exp_q.size()), 32'd0);

        // One-cycle glitch is rejected
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(12);
        check_eq("glitch_addr", 32'(mem_addr), 32'd0);
        check_eq("glitch_din", 32'(mem_din), 32'h99);

        // Framing error discards the byte
        do_reset();
        send_byte(8'hA5, 1'b0);
        check_eq("ferr_set", 32'(frame_err), 32'd1);
        exp_q.push_back({16'd0, 8'h3C});
        send_byte(8'h3C, 1'b1);
        check_eq("ferr_pending", 32'(exp_q.size()), 32'd0);
        check_eq("ferr_din", 32'(mem_din), 32'h3C);
        check_eq("ferr_hold", 32'(frame_err), 32'd1);

        // Reset mid-frame
        rx = 1'b0;
        idle(Cpb);
        rx = 1'b1;
        idle(3 * Cpb);
        rst_n = 1'b0;
        idle(1);
        check_outputs_reset("midrst");
        rst_n = 1'b1;
        idle(3 * Cpb);
        exp_q.push_back({16'd0, 8'h01});
        send_byte(8'h01, 1'b1);
        check_eq("midrst_pending", 32'(exp_q.size()), 32'd0);

        // receive dropped mid-frame: frame completes, next frame ignored
        do_reset();
        exp_q.push_back({16'd0, 8'h5A});
        fork
            send_byte(8'h5A, 1'b1);
            begin
                idle(6);
                receive = 1'b0;
                idle(2);
                check_eq("drop_led", 32'(rx_LED), 32'd1);
            end
        join
        check_eq("drop_pending", 32'(exp_q.size()), 32'd0);
        send_byte(8'h11, 1'b1);
        check_eq("drop_din", 32'(mem_din), 32'h5A);
        check_eq("drop_done", 32'(load_done), 32'd0);
        check_eq("drop_led_off", 32'(rx_LED), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_pixel_loader.md
UART_PIXEL_LOADER -- requirements
Module: uart_pixel_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, means clk cycles per UART bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 Parameter IMG_BYTES, default 16384, means pixel bytes per image (128x128, 8-bit); legal range 1..65536.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 receive  input  1  level; 1 = load session enabled.
REQ-006 rx  input  1  UART serial line, 8N1, LSB first, idle high, asynchronous to clk.
REQ-007 mem_we  output  1  one-cycle write strobe to image memory.
REQ-008 mem_addr  output  16  write address.
REQ-009 mem_din  output  8  pixel byte to write.
REQ-010 load_done  output  1  sticky; all IMG_BYTES written.
REQ-011 frame_err  output  1  sticky; at least one byte had stop bit = 0.
REQ-012 rx_LED  output  1  high while state is not IDLE or receive=1 and load_done=0.

Function
REQ-013 rx SHALL pass a 2-flop synchronizer (reset value 1) before any use; 2-cycle input latency is allowed.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WRITE.
REQ-015 IDLE: on synchronized rx=0 with receive=1 and load_done=0 -> START, bit counter cleared, baud counter cleared.
REQ-016 START: after CLKS_PER_BIT/2 (integer division) cycles sample rx; 0 -> DATA with baud counter cleared; 1 -> IDLE (glitch rejected, no write).
REQ-017 DATA: sample rx every CLKS_PER_BIT cycles; shift in LSB first; after 8th sample -> STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles sample rx; 1 -> WRITE; 0 -> set frame_err, discard byte, -> IDLE.
REQ-019 WRITE: exactly one cycle; mem_we=1, mem_din=received byte, mem_addr=current write pointer; -> IDLE.
REQ-020 Write pointer SHALL increment by 1 after each write; byte counter reaching IMG_BYTES SHALL set load_done in the same cycle as the final write's following edge.
REQ-021 After load_done, further frames SHALL be ignored (no START entry, mem_we stays 0).
REQ-022 Pointer SHALL NOT wrap within a session; IMG_BYTES=65536 ends at address 0xFFFF with load_done set.
REQ-023 receive falling to 0 mid-frame: current frame SHALL complete and be written; no new frame starts.
REQ-024 receive 0->1 rising edge while load_done=1 SHALL clear load_done, frame_err, write pointer and byte count (new image).
REQ-025 Outside WRITE, mem_we=0; mem_addr and mem_din SHALL hold last values.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force: state IDLE, mem_we=0, mem_addr=0, mem_din=0, load_done=0, frame_err=0, rx_LED=0, counters 0, synchronizer 1s; takes priority over all other inputs, including mid-frame.

Verification (CLKS_PER_BIT=4, IMG_BYTES=4 unless noted)
REQ-027 receive=1, send bytes 0x12,0x34,0x56,0x78 -> four mem_we pulses, addr 0..3, din 0x12,0x34,0x56,0x78; load_done=1 after fourth; frame_err=0.
REQ-028 rx low pulse of 1 cycle (shorter than CLKS_PER_BIT/2) -> no write, state back to IDLE, mem_addr unchanged.
REQ-029 byte 0xA5 with stop bit 0, then 0x3C valid -> frame_err=1, single write of 0x3C at addr 0.
REQ-030 fifth byte sent after load_done -> no mem_we; toggle receive 0->1 -> load_done=0, next byte 0x99 written at addr 0.
REQ-031 rst_n=0 during DATA of byte 0xFF -> all outputs at reset values next edge; subsequent byte 0x01 written at addr 0.
REQ-032 receive cleared after start bit of 0x5A -> 0x5A still written; a following frame is not received.
